// File: rtl/regfile_sb_if.sv
// regfile_sb_if : bus bundle for the register file / scoreboard.
//   master (decode/writeback side) drives read addresses, issue and writeback;
//   slave (regfile_sb) returns operands, per-operand busy, issue-ready, err.
// Signals:
//   raddr[p]  read address of port p (packed, port p at bits p*ADDR_W)
//   rdata[p]  read data of port p (combinational)
//   rbusy[p]  operand at port p still has a pending producer
//   iss_valid/iss_addr/iss_ready  destination issue
//   we/waddr/wdata                writeback
//   err                           sticky overflow/underflow flag
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]             rbusy;
  logic                          iss_valid;
  logic [ADDR_W-1:0]             iss_addr;
  logic                          iss_ready;
  logic                          we;
  logic [ADDR_W-1:0]             waddr;
  logic [DATA_W-1:0]             wdata;
  logic                          err;

  modport master (
    output raddr, iss_valid, iss_addr, we, waddr, wdata,
    input  rdata, rbusy, iss_ready, err
  );

  modport slave (
    input  raddr, iss_valid, iss_addr, we, waddr, wdata,
    output rdata, rbusy, iss_ready, err
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb : multi-read-port register file with a per-register
// pending-write scoreboard (saturating counters).
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (clears data, counters, err)
//   rf       regfile_sb_if.slave bundle (reads, issue, writeback, err)
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback data
// and the decremented pending count onto the read ports in the write cycle.
// Register 0 is hard-wired to zero and never busy when ZERO_REG=1.

// One read port: zero-register masking and optional write bypass.
module regfile_sb_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [DATA_W-1:0] i_word,
  input  logic [PEND_W-1:0] i_cnt,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rbusy
);
  logic w_zero;
  assign w_zero = (ZERO_REG != 0) && (i_raddr == '0);

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  assign w_hit = i_we && (i_waddr == i_raddr) && !w_zero;
  assign o_rdata = w_zero ? '0 : (w_hit ? i_wdata : i_word);
  // Busy from cnt-1 on a hit; a hit on cnt==0 is an underflow and must not
  // wrap to "busy", hence cnt>1 rather than cnt-1!=0.
  assign o_rbusy = !w_zero && (w_hit ? (i_cnt > PEND_W'(1)) : (i_cnt != '0));
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{i_we, i_waddr, i_wdata};
  assign o_rdata = w_zero ? '0 : i_word;
  assign o_rbusy = !w_zero && (i_cnt != '0);
`endif
endmodule

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1
) (
  input logic        i_clk,
  input logic        i_rst_n,
  regfile_sb_if.slave rf
);
  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CMAX = '1;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0][PEND_W-1:0] r_cnt;
  logic                         r_err;

  logic [DEPTH-1:0] w_inc;
  logic [DEPTH-1:0] w_dec;
  logic             w_iss_zero;
  logic             w_wr_zero;
  logic             w_same;
  logic             w_ovf;
  logic             w_unf;

  assign w_iss_zero = (ZERO_REG != 0) && (rf.iss_addr == '0);
  assign w_wr_zero  = (ZERO_REG != 0) && (rf.waddr == '0);
  // Issue and writeback hitting one register cancel out.
  assign w_same     = rf.iss_valid && rf.we && (rf.iss_addr == rf.waddr);

  // Register 0 is excluded here so its counter never moves.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_inc[i] = rf.iss_valid && (rf.iss_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0));
      w_dec[i] = rf.we && (rf.waddr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0));
    end
  end

  assign w_ovf = rf.iss_valid && !w_iss_zero && !w_same && (r_cnt[rf.iss_addr] == CMAX);
  assign w_unf = rf.we && !w_wr_zero && !w_same && (r_cnt[rf.waddr] == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (rf.we && !w_wr_zero) r_mem[rf.waddr] <= rf.wdata;
      for (int i = 0; i < DEPTH; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   if (r_cnt[i] != CMAX) r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   if (r_cnt[i] != '0)   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: ;
        endcase
      end
      if (w_ovf || w_unf) r_err <= 1'b1;
    end
  end

  // A writeback to the saturated register this cycle frees a slot.
  assign rf.iss_ready = w_iss_zero || (r_cnt[rf.iss_addr] != CMAX) ||
                        (rf.we && (rf.waddr == rf.iss_addr));
  assign rf.err = r_err;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PEND_W(PEND_W), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .i_raddr (rf.raddr[p]),
      .i_word  (r_mem[rf.raddr[p]]),
      .i_cnt   (r_cnt[rf.raddr[p]]),
      .i_we    (rf.we),
      .i_waddr (rf.waddr),
      .i_wdata (rf.wdata),
      .o_rdata (rf.rdata[p]),
      .o_rbusy (rf.rbusy[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) rf ();
  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .PEND_W(2), .ZERO_REG(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .rf(rf)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        busy;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  task automatic idle();
    rf.iss_valid = 1'b0; rf.iss_addr = '0;
    rf.we = 1'b0; rf.waddr = '0; rf.wdata = '0;
    rf.raddr[0] = '0; rf.raddr[1] = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    rf.iss_valid = 1'b1; rf.iss_addr = a; step(); rf.iss_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    rf.we = 1'b1; rf.waddr = a; rf.wdata = d; step(); rf.we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      rf.raddr[0] = 5'(a); rf.raddr[1] = 5'(31 - a); rf.iss_addr = 5'(a);
      #1;
      sb.push_back('{0, 32'h0, 1'b0, "reset_p0"});
      sb.push_back('{1, 32'h0, 1'b0, "reset_p1"});
      while (sb.size() > 0) begin
        e = sb.pop_front(); total++;
        if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
          bad++;
          $display("FAIL %s a=%0d: got data=%h busy=%b want data=%h busy=%b",
                   e.tag, a, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
        end
      end
      total++;
      if (rf.iss_ready !== 1'b1) begin
        bad++; $display("FAIL reset_iss_ready a=%0d: got %b want 1", a, rf.iss_ready);
      end
    end
    total++;
    if (rf.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", rf.err); end
    step();
    rst_n = 1'b1;
    idle();
    #1;
  endtask

  task automatic test_write_read();
    do_reset();
    wb(5'd0, 32'h1234);
    rf.raddr[0] = 5'd0; #1;
    sb.push_back('{0, 32'h0, 1'b0, "zero_reg_write"});
    wb(5'd5, 32'hDEADBEEF);
    rf.raddr[1] = 5'd5; #1;
    sb.push_back('{1, 32'hDEADBEEF, 1'b0, "r5_read"});
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
        bad++;
        $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b",
                 e.tag, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
      end
    end
    // r0 write is harmless, r5 write with no producer is an underflow
    total++;
    if (rf.err !== 1'b1) begin bad++; $display("FAIL r5_underflow_err: got %b want 1", rf.err); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 3; k++) issue(5'd7);
    rf.iss_addr = 5'd7; rf.raddr[0] = 5'd7; #1;
    total++;
    if (rf.iss_ready !== 1'b0) begin bad++; $display("FAIL sat_iss_ready: got %b want 0", rf.iss_ready); end
    total++;
    if (rf.err !== 1'b0) begin bad++; $display("FAIL sat_err_before: got %b want 0", rf.err); end
    rf.we = 1'b1; rf.waddr = 5'd7; #1;
    total++;
    if (rf.iss_ready !== 1'b1) begin bad++; $display("FAIL sat_iss_ready_wb: got %b want 1", rf.iss_ready); end
    rf.we = 1'b0;
    issue(5'd7);
    rf.iss_addr = 5'd7; #1;
    total++;
    if (rf.err !== 1'b1) begin bad++; $display("FAIL sat_overflow_err: got %b want 1", rf.err); end
    rf.raddr[0] = 5'd7;
    for (int k = 0; k < 3; k++) begin
      wb(5'd7, 32'(100 + k));
      rf.raddr[0] = 5'd7; #1;
      sb.push_back('{0, 32'(100 + k), (k < 2), "sat_drain"});
      while (sb.size() > 0) begin
        e = sb.pop_front(); total++;
        if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
          bad++;
          $display("FAIL %s k=%0d: got data=%h busy=%b want data=%h busy=%b",
                   e.tag, k, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue(5'd3);
    rf.iss_valid = 1'b1; rf.iss_addr = 5'd3;
    rf.we = 1'b1; rf.waddr = 5'd3; rf.wdata = 32'h33;
    step();
    idle(); rf.raddr[0] = 5'd3; #1;
    sb.push_back('{0, 32'h33, 1'b1, "same_cycle_r3"});
    total++;
    if (rf.err !== 1'b0) begin bad++; $display("FAIL same_cycle_err: got %b want 0", rf.err); end
    wb(5'd9, 32'h99);
    rf.raddr[1] = 5'd9; #1;
    sb.push_back('{1, 32'h99, 1'b0, "underflow_r9"});
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
        bad++;
        $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b",
                 e.tag, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
      end
    end
    total++;
    if (rf.err !== 1'b1) begin bad++; $display("FAIL underflow_err: got %b want 1", rf.err); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue(5'd4);
    wb(5'd4, 32'h1111);
    issue(5'd4);
    rf.raddr[0] = 5'd4; rf.raddr[1] = 5'd0;
    rf.we = 1'b1; rf.waddr = 5'd4; rf.wdata = 32'hA5A5; #1;
`ifdef REGFILE_BYPASS_EN
    sb.push_back('{0, 32'hA5A5, 1'b0, "bypass_same_cycle"});
`else
    sb.push_back('{0, 32'h1111, 1'b1, "nobypass_same_cycle"});
`endif
    sb.push_back('{1, 32'h0, 1'b0, "bypass_r0_port"});
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
        bad++;
        $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b",
                 e.tag, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
      end
    end
    step();
    rf.we = 1'b0; #1;
    sb.push_back('{0, 32'hA5A5, 1'b0, "bypass_after_edge"});
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
        bad++;
        $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b",
                 e.tag, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
      end
    end
    total++;
    if (rf.err !== 1'b0) begin bad++; $display("FAIL bypass_err: got %b want 0", rf.err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) begin
        rf.raddr[1] = 5'(k - 1); #1;
        while (sb.size() > 0) begin
          e = sb.pop_front(); total++;
          if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
            bad++;
            $display("FAIL %s k=%0d: got data=%h busy=%b want data=%h busy=%b",
                     e.tag, k, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
          end
        end
      end
      if (k <= 8) begin
        rf.we = 1'b1; rf.waddr = 5'(k); rf.wdata = 32'h5000_0000 + 32'(k * 17);
        sb.push_back('{1, 32'h5000_0000 + 32'(k * 17), 1'b0, "b2b_read"});
        step();
        rf.we = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) issue(5'd2);
    wb(5'd6, 32'h66);
    rf.raddr[0] = 5'd2; rf.raddr[1] = 5'd6; rf.iss_addr = 5'd2; #1;
    total++;
    if (rf.iss_ready !== 1'b0 || rf.err !== 1'b1 || rf.rbusy[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got ready=%b err=%b busy=%b want 0 1 1",
               rf.iss_ready, rf.err, rf.rbusy[0]);
    end
    #1; rst_n = 1'b0; #1;
    sb.push_back('{0, 32'h0, 1'b0, "mid_reset_p0"});
    sb.push_back('{1, 32'h0, 1'b0, "mid_reset_p1"});
    while (sb.size() > 0) begin
      e = sb.pop_front(); total++;
      if (rf.rdata[e.port] !== e.data || rf.rbusy[e.port] !== e.busy) begin
        bad++;
        $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b",
                 e.tag, rf.rdata[e.port], rf.rbusy[e.port], e.data, e.busy);
      end
    end
    total++;
    if (rf.iss_ready !== 1'b1 || rf.err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_flags: got ready=%b err=%b want 1 0", rf.iss_ready, rf.err);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_saturate();
    test_same_cycle();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated per-register pending-write scoreboard, the next-generation register file for the pipelined CPU core. It sits between decode (reads, destination issue) and writeback (register write). It supplies operands, a per-operand busy indication for hazard stalls, and an issue-ready flag. Register 0 is optionally hard-wired to zero.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; depth = 2**ADDR_W
- NUM_RD, 2: number of read ports, at least 1
- PEND_W, 2: width of each pending-write counter; max outstanding = 2**PEND_W-1
- ZERO_REG, 1: 1 = register 0 reads 0, is never written, and is never busy

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- raddr  in  NUM_RD*ADDR_W  read addresses; port p is bits [p*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational, same packing
- rbusy  out  NUM_RD  1 = the operand at port p still has a pending producer
- iss_valid  in  1  a destination register is being issued this cycle
- iss_addr  in  ADDR_W  destination register of the issued instruction
- iss_ready  out  1  1 = the pending counter of iss_addr is not saturated
- we  in  1  writeback strobe
- waddr  in  ADDR_W  writeback address
- wdata  in  DATA_W  writeback data
- err  out  1  sticky error: counter overflow or underflow attempted

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W counters of PEND_W bits each.
- Read: rdata[p] = mem[raddr[p]]. When ZERO_REG=1 and raddr[p]==0, rdata[p] is 0.
- Write: at the rising edge when we=1, mem[waddr] <= wdata. The write is ignored when ZERO_REG=1 and waddr==0.
- Counter update at the rising edge, per register i, where inc = iss_valid&&iss_addr==i and dec = we&&waddr==i:
  - inc only: cnt+1.
  - dec only: cnt-1.
  - inc and dec together: cnt unchanged.
- Overflow: inc while cnt==max and no dec leaves cnt unchanged and sets err.
- Underflow: dec while cnt==0 and no inc leaves cnt at 0 and sets err. The data is still written.
- iss_ready = (cnt[iss_addr] != max) || (we && waddr==iss_addr). It is always 1 for register 0 when ZERO_REG=1.
- rbusy[p] = cnt[raddr[p]] != 0, subject to the bypass rule under Configuration. It is always 0 for register 0 when ZERO_REG=1.
- Register 0 with ZERO_REG=1: the counter never changes, and issue or writeback to it never sets err.
- err stays set until reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system) clears:
  - all registers to 0
  - all counters to 0
  - err to 0
- Outputs after reset: rdata=0, rbusy=0, iss_ready=1.
- Read latency is 0 cycles. A write is visible on the read path from the cycle after the edge, or in the same cycle with bypass.
- Scoreboard latency: an issue at edge N makes rbusy=1 from cycle N+1.
- A reset asserted mid-operation discards all pending counts and data immediately.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read bypass is active.
  - When we=1 and waddr==raddr[p] (excluding register 0 when ZERO_REG=1), rdata[p]=wdata in the same cycle.
  - rbusy[p] is computed from cnt-1, so the last outstanding write unblocks the consumer in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - rdata[p] shows the old value during the write cycle.
  - rbusy[p] stays 1 until the edge.
  - The consumer stalls one extra cycle.

## Test plan
- Reset, then read every address on all ports -> rdata=0, rbusy=0, iss_ready=1, err=0.
- Write 0xDEADBEEF to r5, then read r5 on port 1 the next cycle -> 0xDEADBEEF. Write 0x1234 to r0 with ZERO_REG=1 -> r0 reads 0.
- Issue r7 three times with PEND_W=2 -> iss_ready=0 for r7. A fourth issue sets err. Three writebacks -> rbusy for r7 returns to 0 after the third.
- Issue and writeback r3 in the same cycle with cnt=1 -> cnt stays 1 and rbusy stays 1. Writeback to r9 with cnt=0 -> data written, err=1.
- With REGFILE_BYPASS_EN, cnt[r4]=1, and we=1 with waddr=4, wdata=0xA5A5 while raddr[0]=4 -> same cycle rdata[0]=0xA5A5, rbusy[0]=0. Without the macro -> old data shown, rbusy[0]=1.
- Assert rst_n low mid-sequence with pending counts -> all outputs return to reset values immediately, without waiting for a clock edge.
